rr_grant_encoder: RTL

- Parametrised, clocked successor to the 3-to-8 decoder / 8-to-3 encoder pair.
- Takes an N-bit request vector and arbitrates one winner, in either fixed-priority or round-robin mode.
- Presents the winner both as a one-hot grant (decoder form) and as a binary index (encoder form), with a valid/ack handshake.
- Sits between request sources and a shared resource; the downstream consumer acknowledges each grant.

---
 rtl/rr_grant_encoder.sv | 95 +++++++++
 1 files changed

// File: rtl/rr_grant_encoder.sv
// Parametrised request arbiter (fixed priority or round robin) that presents the
// winner as a registered one-hot grant plus binary index with a valid/ack handshake.
module rr_grant_encoder #(
  parameter int N    = 8,
  parameter int W    = 3,
  parameter int MODE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         valid,
  output logic [7:0]   busy_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [W-1:0]   ptr;
  logic [W-1:0]   next_ptr;
  logic [W-1:0]   base;
  logic [W-1:0]   win_idx;
  logic [W:0]     win_sum;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   win_onehot;
  logic           win_found;

  if (W != $clog2(N) || N < 2 || N > 64) begin : g_param_err
    $error("rr_grant_encoder: N must be 2..64 and W must equal ceil(log2(N))");
  end

  // On an accepted grant the search already starts from the post-update pointer,
  // which is what makes back-to-back grants rotate without a bubble.
  assign next_ptr = (grant_idx == W'(N - 1)) ? '0 : grant_idx + 1'b1;
  assign base     = (MODE == 0) ? '0 : ((state == GRANT) ? next_ptr : ptr);
  assign req_rot  = N'({req, req} >> base);
  assign valid    = (state == GRANT);

  always_comb begin
    win_found  = 1'b0;
    win_sum    = '0;
    win_onehot = '0;
    for (int k = 0; k < N; k++) begin
      if (!win_found && req_rot[k]) begin
        win_found = 1'b1;
        win_sum   = {1'b0, base} + (W+1)'(k);
      end
    end
    if (win_sum >= (W+1)'(N)) win_sum = win_sum - (W+1)'(N);
    win_idx             = win_sum[W-1:0];
    win_onehot[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      busy_cnt  <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && win_found) begin
            state     <= GRANT;
            grant     <= win_onehot;
            grant_idx <= win_idx;
            busy_cnt  <= '0;
          end
        end
        GRANT: begin
          if (ack) begin
            busy_cnt <= '0;
            if (MODE != 0) ptr <= next_ptr;
            if (en && win_found) begin
              grant     <= win_onehot;
              grant_idx <= win_idx;
            end else begin
              state     <= IDLE;
              grant     <= '0;
              grant_idx <= '0;
            end
          end else if (busy_cnt != 8'hFF) begin
            busy_cnt <= busy_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
